// File: rtl/io_peripheral_responder.sv
// Core-facing command/response responder bridged to a host through an RX and a TX FIFO.
// A READ on an empty RX FIFO parks in WAIT until host data arrives or READ_TIMEOUT expires.

module io_peripheral_responder #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned READ_TIMEOUT = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            to_peripheral,
  input  logic [DATA_WIDTH-1:0] to_peripheral_data,
  input  logic                  to_peripheral_valid,
  output logic [1:0]            from_peripheral,
  output logic [DATA_WIDTH-1:0] from_peripheral_data,
  output logic                  from_peripheral_valid,
  input  logic [DATA_WIDTH-1:0] host_in_data,
  input  logic                  host_in_valid,
  output logic                  host_in_ready,
  output logic [DATA_WIDTH-1:0] host_out_data,
  output logic                  host_out_valid,
  input  logic                  host_out_ready
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TW = $clog2(READ_TIMEOUT) + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] WAIT_LAST = TW'(READ_TIMEOUT - 1);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] RSP_NONE  = 2'b00;
  localparam logic [1:0] RSP_ACK   = 2'b01;
  localparam logic [1:0] RSP_DATA  = 2'b10;
  localparam logic [1:0] RSP_ERROR = 2'b11;

  typedef enum logic [1:0] {IDLE, RESP, WAIT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]         rx_wr, rx_rd, tx_wr, tx_rd;
  logic [CW-1:0]         rx_count, tx_count, rx_count_nxt, tx_count_nxt;
  logic [TW-1:0]         wait_cnt;

  logic                  rx_empty, tx_empty, tx_full;
  logic                  cmd_fire, tx_push, tx_pop;
  logic                  rx_in_fire, rx_bypass, rx_push, rx_pop;
  logic [DATA_WIDTH-1:0] status_word;

  // Command decode, FIFO handshakes and next occupancies.
  // A host word arriving while WAIT sees an empty RX FIFO is answered directly (bypass),
  // so data landing in the final wait cycle still beats the timeout.
  always_comb begin
    rx_empty    = (rx_count == '0);
    tx_empty    = (tx_count == '0);
    tx_full     = (tx_count == DEPTH_C);
    cmd_fire    = to_peripheral_valid && (to_peripheral != CMD_NONE) && (state == IDLE);
    tx_push     = cmd_fire && (to_peripheral == CMD_WRITE) && !tx_full;
    tx_pop      = !tx_empty && host_out_ready;
    rx_in_fire  = host_in_valid && host_in_ready;
    rx_bypass   = (state == WAIT) && rx_empty && rx_in_fire;
    rx_push     = rx_in_fire && !rx_bypass;
    rx_pop      = !rx_empty && ((cmd_fire && (to_peripheral == CMD_READ)) || (state == WAIT));

    rx_count_nxt = rx_count;
    if (rx_push && !rx_pop)      rx_count_nxt = rx_count + CW'(1);
    else if (!rx_push && rx_pop) rx_count_nxt = rx_count - CW'(1);

    tx_count_nxt = tx_count;
    if (tx_push && !tx_pop)      tx_count_nxt = tx_count + CW'(1);
    else if (!tx_push && tx_pop) tx_count_nxt = tx_count - CW'(1);

    status_word        = '0;
    status_word[15:8]  = 8'(rx_count);
    status_word[7:0]   = 8'(tx_count);
  end

  assign host_out_valid = !tx_empty;
  assign host_out_data  = tx_mem[tx_rd];

  // FIFO storage; stale contents are harmless because pointers are reset.
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr] <= host_in_data;
    if (tx_push) tx_mem[tx_wr] <= to_peripheral_data;
  end

  // Pointers, occupancies, FSM and registered response outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state                 <= IDLE;
      rx_wr                 <= '0;
      rx_rd                 <= '0;
      tx_wr                 <= '0;
      tx_rd                 <= '0;
      rx_count              <= '0;
      tx_count              <= '0;
      wait_cnt              <= '0;
      host_in_ready         <= 1'b0;
      from_peripheral       <= RSP_NONE;
      from_peripheral_data  <= '0;
      from_peripheral_valid <= 1'b0;
    end else begin
      rx_count      <= rx_count_nxt;
      tx_count      <= tx_count_nxt;
      host_in_ready <= (rx_count_nxt != DEPTH_C);
      if (rx_push) rx_wr <= rx_wr + AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + AW'(1);
      if (tx_push) tx_wr <= tx_wr + AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + AW'(1);

      from_peripheral       <= RSP_NONE;
      from_peripheral_data  <= '0;
      from_peripheral_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_fire) begin
            state                 <= RESP;
            from_peripheral_valid <= 1'b1;
            if (to_peripheral == CMD_WRITE) begin
              from_peripheral <= tx_full ? RSP_ERROR : RSP_ACK;
            end else if (to_peripheral == CMD_READ) begin
              if (!rx_empty) begin
                from_peripheral      <= RSP_DATA;
                from_peripheral_data <= rx_mem[rx_rd];
              end else begin
                state                 <= WAIT;
                from_peripheral_valid <= 1'b0;
                wait_cnt              <= '0;
              end
            end else begin
              from_peripheral      <= RSP_DATA;
              from_peripheral_data <= status_word;
            end
          end
        end
        RESP: state <= IDLE;
        WAIT: begin
          if (!rx_empty) begin
            state                 <= RESP;
            from_peripheral_valid <= 1'b1;
            from_peripheral       <= RSP_DATA;
            from_peripheral_data  <= rx_mem[rx_rd];
          end else if (rx_bypass) begin
            state                 <= RESP;
            from_peripheral_valid <= 1'b1;
            from_peripheral       <= RSP_DATA;
            from_peripheral_data  <= host_in_data;
          end else if (wait_cnt == WAIT_LAST) begin
            state                 <= RESP;
            from_peripheral_valid <= 1'b1;
            from_peripheral       <= RSP_ERROR;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
